// File: rtl/z80_bus_pkg.sv
// Shared types and defaults for the tv80s bus-request arbiter and its timer.
// Provides the FSM state enum, the timer width, the parameter defaults and the length clamp.
package z80_bus_pkg;

    localparam int TMR_W           = 8;
    localparam int HOLD_MAX_DEF    = 100;
    localparam int ACK_TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_REL,
        ST_GAP
    } arb_state_e;

    // A zero length or an over-long request both collapse to the maximum hold.
    function automatic logic [TMR_W-1:0] clamp_len(
        input logic [TMR_W-1:0] len,
        input logic [TMR_W-1:0] max_len
    );
        if (len == '0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/z80_busrq_timer.sv
// Loadable down counter shared by the acknowledge timeout and the grant hold.
// expire_o marks the last counted cycle (count == 1), so a load of N spans exactly N cycles.
module z80_busrq_timer
    import z80_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/z80_busrq_arb.sv
// Hands the tv80s memory bus to a secondary master via BUSRQ/BUSAK with
// bounded hold time, acknowledge timeout and a guaranteed CPU gap between grants.
module z80_busrq_arb
    import z80_bus_pkg::*;
#(
    parameter int HOLD_MAX    = HOLD_MAX_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dma_req,
    input  logic [TMR_W-1:0] dma_len,
    input  logic             busak_n,
    output logic             busrq_n,
    output logic             dma_gnt,
    output logic             mem_sel,
    output logic             dma_done,
    output logic             ack_timeout,
    output logic             busy
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("z80_busrq_arb: HOLD_MAX must lie in 1..255");
    end
    if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_ack_timeout
        $error("z80_busrq_arb: ACK_TIMEOUT must lie in 1..255");
    end

    localparam logic [TMR_W-1:0] HOLD_C = TMR_W'(HOLD_MAX);
    localparam logic [TMR_W-1:0] ACK_C  = TMR_W'(ACK_TIMEOUT);

    arb_state_e       state_q, state_d;
    logic [TMR_W-1:0] len_q, len_d;
    logic             withdrawn_q, withdrawn_d;
    logic             granted_q, granted_d;
    logic             busrq_n_q, gnt_q, done_q, ack_to_q, busy_q;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_expire;
    logic             timeout_evt;

    z80_busrq_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        withdrawn_d = withdrawn_q;
        granted_d   = granted_q;
        tmr_load    = 1'b0;
        tmr_val     = ACK_C;
        timeout_evt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                withdrawn_d = 1'b0;
                granted_d   = 1'b0;
                if (dma_req) begin
                    state_d  = ST_REQ;
                    len_d    = clamp_len(dma_len, HOLD_C);
                    tmr_load = 1'b1;
                    tmr_val  = ACK_C;
                end
            end
            ST_REQ: begin
                // Once BUSRQ is out it stays out until the CPU answers, even if the master gave up.
                if (!busak_n) begin
                    if (withdrawn_q || !dma_req) begin
                        state_d = ST_REL;
                    end else begin
                        state_d   = ST_GRANT;
                        granted_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = len_q;
                    end
                end else if (tmr_expire) begin
                    state_d     = ST_IDLE;
                    timeout_evt = 1'b1;
                end else if (!dma_req) begin
                    withdrawn_d = 1'b1;
                end
            end
            ST_GRANT: begin
                // Losing BUSAK mid-grant also ends the grant so dma_gnt never outlives the acknowledge.
                if (!dma_req || tmr_expire || busak_n) begin
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                if (busak_n) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tmr_en = (state_q == ST_REQ || state_q == ST_GRANT) && !tmr_load;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            withdrawn_q <= 1'b0;
            granted_q   <= 1'b0;
            busrq_n_q   <= 1'b1;
            gnt_q       <= 1'b0;
            done_q      <= 1'b0;
            ack_to_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            withdrawn_q <= withdrawn_d;
            granted_q   <= granted_d;
            busrq_n_q   <= !(state_d == ST_REQ || state_d == ST_GRANT);
            gnt_q       <= (state_d == ST_GRANT);
            done_q      <= (state_d == ST_GAP) && granted_q;
            ack_to_q    <= timeout_evt;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign busrq_n     = busrq_n_q;
    assign dma_gnt     = gnt_q;
    assign mem_sel     = gnt_q;
    assign dma_done    = done_q;
    assign ack_timeout = ack_to_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_z80_busrq_arb.sv
// Directed bench for z80_busrq_arb against a behavioural tv80s bus-acknowledge model.
// Expected grant lengths are queued when a request is driven and popped as each grant ends.
module tb_z80_busrq_arb;

    logic       clk;
    logic       reset;
    logic       dma_req;
    logic [7:0] dma_len;
    logic       busak_n;
    logic       busrq_n;
    logic       dma_gnt;
    logic       mem_sel;
    logic       dma_done;
    logic       ack_timeout;
    logic       busy;

    logic       cpu_dead;
    logic [1:0] ack_pipe;
    logic       busak_prev;
    int         cyc;
    int         pc;

    int         errors;
    int         checks;
    int         exp_q[$];
    int         gnt_run;
    int         gnt_events;
    int         done_cnt;

    localparam int W_GNT1 = 0;
    localparam int W_GNT0 = 1;
    localparam int W_DONE = 2;
    localparam int W_TO   = 3;
    localparam int W_RQ0  = 4;

    z80_busrq_arb #(.HOLD_MAX(100), .ACK_TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .dma_req     (dma_req),
        .dma_len     (dma_len),
        .busak_n     (busak_n),
        .busrq_n     (busrq_n),
        .dma_gnt     (dma_gnt),
        .mem_sel     (mem_sel),
        .dma_done    (dma_done),
        .ack_timeout (ack_timeout),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tv80s model: acknowledges BUSRQ two cycles late, releases two cycles after it goes away,
    // and runs its NOP loop (PC increments) whenever it owns the bus.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_pipe <= 2'b00;
            pc       <= 0;
        end else begin
            ack_pipe <= {ack_pipe[0], !busrq_n && !cpu_dead};
            if (busak_n) pc <= pc + 1;
        end
    end
    assign busak_n = !ack_pipe[1];

    initial begin
        cyc        = 0;
        busak_prev = 1'b1;
    end
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        busak_prev <= busak_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        gnt_run    = 0;
        gnt_events = 0;
        done_cnt   = 0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("mem_sel_eq_gnt", {31'd0, mem_sel}, {31'd0, dma_gnt});
            chk("done_to_exclusive", {31'd0, dma_done & ack_timeout}, 32'd0);
            if (dma_gnt) chk("gnt_needs_ack", {31'd0, busak_prev}, 32'd0);
        end
        if (dma_done) done_cnt++;
        if (dma_gnt) begin
            gnt_run++;
        end else if (gnt_run > 0) begin
            gnt_events++;
            if (exp_q.size() > 0) chk("grant_len", gnt_run, exp_q.pop_front());
            gnt_run = 0;
        end
    end

    task automatic wait_for(input int which, input int limit, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (which)
                W_GNT1:  hit = dma_gnt;
                W_GNT0:  hit = !dma_gnt;
                W_DONE:  hit = dma_done;
                W_TO:    hit = ack_timeout;
                default: hit = !busrq_n;
            endcase
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic run_grant(input logic [7:0] len, input int exp_len, input string tag);
        int d0;
        d0      = done_cnt;
        dma_len = len;
        dma_req = 1'b1;
        exp_q.push_back(exp_len);
        wait_for(W_GNT1, 20, {tag, "_gnt_rise"});
        wait_for(W_GNT0, 300, {tag, "_gnt_fall"});
        dma_req = 1'b0;
        wait_for(W_DONE, 20, {tag, "_done_seen"});
        repeat (5) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d0;
        int g0;
        int t0;
        int pcb;
        int gap;
        bit hit;

        reset    = 1'b1;
        dma_req  = 1'b0;
        dma_len  = 8'd0;
        cpu_dead = 1'b0;

        #20;
        chk("rst_busrq_n", {31'd0, busrq_n}, 32'd1);
        chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("rst_mem_sel", {31'd0, mem_sel}, 32'd0);
        chk("rst_dma_done", {31'd0, dma_done}, 32'd0);
        chk("rst_ack_timeout", {31'd0, ack_timeout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        #10;
        reset = 1'b0;

        while (cyc < 300) @(posedge clk);
        #1;
        chk("cpu_running", {31'd0, pc > 200}, 32'd1);

        // Basic 10-cycle grant with busrq_n latency check.
        d0      = done_cnt;
        dma_len = 8'd10;
        dma_req = 1'b1;
        exp_q.push_back(10);
        @(negedge clk);
        chk("busrq_n_before_edge", {31'd0, busrq_n}, 32'd1);
        @(negedge clk);
        chk("busrq_n_one_cycle", {31'd0, busrq_n}, 32'd0);
        chk("busy_in_req", {31'd0, busy}, 32'd1);
        wait_for(W_GNT1, 20, "g10_gnt_rise");
        wait_for(W_GNT0, 50, "g10_gnt_fall");
        chk("g10_rel_busrq_n", {31'd0, busrq_n}, 32'd1);
        dma_req = 1'b0;
        wait_for(W_DONE, 20, "g10_done_seen");
        pcb = pc;
        repeat (20) @(negedge clk);
        chk("g10_done_count", done_cnt - d0, 1);
        chk("g10_pc_advances", {31'd0, pc > pcb}, 32'd1);

        // Length clamping and boundaries.
        run_grant(8'd0, 100, "len0");
        run_grant(8'd200, 100, "len200");
        run_grant(8'd101, 100, "len101");
        run_grant(8'd100, 100, "len100");
        run_grant(8'd1, 1, "len1");

        // CPU never acknowledges.
        cpu_dead = 1'b1;
        d0       = done_cnt;
        g0       = gnt_events;
        dma_len  = 8'd10;
        dma_req  = 1'b1;
        wait_for(W_RQ0, 5, "to_busrq_fall");
        t0 = cyc;
        wait_for(W_TO, 100, "to_pulse_seen");
        chk("to_delay", cyc - t0, 64);
        chk("to_busrq_n_high", {31'd0, busrq_n}, 32'd1);
        dma_req = 1'b0;
        @(negedge clk);
        chk("to_pulse_width", {31'd0, ack_timeout}, 32'd0);
        repeat (5) @(negedge clk);
        chk("to_busy_idle", {31'd0, busy}, 32'd0);
        chk("to_no_grant", gnt_events - g0, 0);
        chk("to_no_done", done_cnt - d0, 0);
        cpu_dead = 1'b0;

        // Early release: request dropped during the 4th grant cycle.
        d0      = done_cnt;
        dma_len = 8'd10;
        dma_req = 1'b1;
        exp_q.push_back(4);
        wait_for(W_GNT1, 20, "early_gnt_rise");
        repeat (3) @(posedge clk);
        #1;
        dma_req = 1'b0;
        wait_for(W_GNT0, 10, "early_gnt_fall");
        chk("early_busrq_n", {31'd0, busrq_n}, 32'd1);
        wait_for(W_DONE, 20, "early_done_seen");
        repeat (5) @(negedge clk);
        chk("early_done_count", done_cnt - d0, 1);

        // Request held across two grants: CPU must get the bus in between.
        d0      = done_cnt;
        dma_len = 8'd5;
        dma_req = 1'b1;
        exp_q.push_back(5);
        exp_q.push_back(5);
        wait_for(W_GNT1, 20, "two_gnt1_rise");
        wait_for(W_GNT0, 20, "two_gnt1_fall");
        gap = 0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (dma_gnt) hit = 1'b1;
            else if (busrq_n && busak_n) gap++;
        end
        chk("two_gnt2_rise", {31'd0, hit}, 32'd1);
        chk("two_cpu_gap", {31'd0, gap >= 1}, 32'd1);
        wait_for(W_GNT0, 20, "two_gnt2_fall");
        dma_req = 1'b0;
        wait_for(W_DONE, 20, "two_done_seen");
        repeat (5) @(negedge clk);
        chk("two_done_count", done_cnt - d0, 2);

        // Reset pulsed mid-grant.
        d0      = done_cnt;
        dma_len = 8'd50;
        dma_req = 1'b1;
        wait_for(W_GNT1, 20, "rstg_gnt_rise");
        repeat (5) @(posedge clk);
        #1;
        reset   = 1'b1;
        dma_req = 1'b0;
        #1;
        chk("rstg_busrq_n", {31'd0, busrq_n}, 32'd1);
        chk("rstg_mem_sel", {31'd0, mem_sel}, 32'd0);
        chk("rstg_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstg_no_done", done_cnt - d0, 0);
        chk("rstg_busy", {31'd0, busy}, 32'd0);
        run_grant(8'd7, 7, "after_rst");

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "time limit");
    end

endmodule
